sseg_scan_n: RTL

SSEG_SCAN_N -- requirements
Module: sseg_scan_n

---
 rtl/sseg_scan_n.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_n.sv
// Multiplexed N-digit seven-segment scanner with frame-atomic display updates,
// leading-zero blanking and per-slot PWM brightness control.
module sseg_scan_n #(
    parameter int DIGITS   = 4,
    parameter int DIV      = 100000,
    parameter int BRIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  btnC,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]       PRESC_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0]       IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] PWM_MAX   = {BRIGHT_W{1'b1}};

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic [DIGITS-1:0]     shdp_q, shdp_d, dispdp_q, dispdp_d;
    logic                  pending_q, pending_d;
    logic                  frame_q, frame_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  tick_s;
    logic                  lit_s;
    logic                  zero_run_s;
    logic [DIGITS-1:0]     blank_s;
    logic [3:0]            nib_s;

    // Prescaler, digit index, PWM counter; frame is registered one cycle ahead
    // so it is high exactly in the cycle of the wrapping tick.
    always_comb begin
        tick_s  = (presc_q == PRESC_MAX);
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        pwm_d   = pwm_q;
        if (tick_s) begin
            presc_d = '0;
            pwm_d   = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            if (pwm_q != PWM_MAX) begin
                pwm_d = pwm_q + BRIGHT_W'(1);
            end else begin
                pwm_d = pwm_q;
            end
        end
        frame_d = (presc_d == PRESC_MAX) && (idx_d == IDX_MAX);
    end

    // Shadow/display double buffering: transfer on frame, last load wins
    always_comb begin
        shadow_d  = shadow_q;
        shdp_d    = shdp_q;
        disp_d    = disp_q;
        dispdp_d  = dispdp_q;
        pending_d = pending_q;
        if (frame_q && pending_q) begin
            disp_d    = shadow_q;
            dispdp_d  = shdp_q;
            pending_d = 1'b0;
        end else begin
            disp_d    = disp_q;
            dispdp_d  = dispdp_q;
        end
        if (load) begin
            shadow_d  = value;
            shdp_d    = dp_in;
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
            shdp_d    = shdp_q;
        end
    end

    // Leading-zero blanking mask, scanning from the top digit downward
    always_comb begin
        zero_run_s = 1'b1;
        blank_s    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run_s = zero_run_s && (disp_q[4*k +: 4] == 4'h0);
            blank_s[k] = blank_lz && zero_run_s && (k != 0);
        end
    end

    // Next output values for the active slot
    always_comb begin
        nib_s = disp_q[{idx_q, 2'b00} +: 4];
        lit_s = (pwm_q <= bright) && !blank_s[idx_q];
        an_d  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = !(lit_s && (idx_q == IW'(k)));
        end
        if (lit_s) begin
            seg_d = hex_decode(nib_s);
            dp_d  = !dispdp_q[idx_q];
        end else begin
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (btnC) begin
            presc_q   <= '0;
            idx_q     <= '0;
            pwm_q     <= '0;
            shadow_q  <= '0;
            shdp_q    <= '0;
            disp_q    <= '0;
            dispdp_q  <= '0;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
            an_q      <= '1;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pwm_q     <= pwm_d;
            shadow_q  <= shadow_d;
            shdp_q    <= shdp_d;
            disp_q    <= disp_d;
            dispdp_q  <= dispdp_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign pending = pending_q;
    assign frame   = frame_q;

endmodule
